// File: rtl/bf16_pkg.sv
// Shared BF16 definitions for the PE multiplier and accumulator.
package bf16_pkg;

    localparam int BF16_EXP_W = 8;
    localparam int BF16_MAN_W = 7;
    localparam int BIAS       = 127;
    localparam int EXP_MAX    = 2 * BIAS + 1;
    localparam int SIG_W      = 11;
    localparam int SUM_W      = SIG_W + 1;

    localparam logic [15:0] BF16_QNAN = 16'h7FC0;
    localparam logic [15:0] BF16_PINF = 16'h7F80;
    localparam logic [15:0] BF16_NINF = 16'hFF80;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        NORM  = 2'd2
    } acc_state_t;

    function automatic logic bf16_is_nan(input logic [15:0] v);
        return (&v[14:7]) && (|v[6:0]);
    endfunction

    function automatic logic bf16_is_inf(input logic [15:0] v);
        return (&v[14:7]) && (v[6:0] == 7'd0);
    endfunction

endpackage

// File: rtl/acc_bf16_lzc12.sv
// Leading-zero counter for the 12-bit NORM-stage sum; all-zero input gives 12.
module lzc12 (
    input  logic [11:0] vec,
    output logic [3:0]  cnt
);

    always_comb begin
        cnt = 4'd12;
        // Ascending scan: the highest set bit is written last and wins.
        for (int i = 0; i < 12; i++) begin
            if (vec[i]) cnt = 4'(11 - i);
        end
    end

endmodule

// File: rtl/acc_bf16.sv
// Sequential BF16 accumulator: align stage, then add/normalize/round-to-nearest-even.
// Handshake: an operand is taken on a rising edge where in_valid && in_ready; in_ready is high only in IDLE with clr low.
module acc_bf16
    import bf16_pkg::*;
#(
    parameter int EXP_W = BF16_EXP_W,
    parameter int MAN_W = BF16_MAN_W
) (
    input  logic                   clk,
    input  logic                   nRST,
    input  logic                   clr,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in_bf16,
    input  logic                   in_last,
    input  logic                   in_ovf,
    input  logic                   in_unf,
    input  logic                   in_invalid,
    output logic                   out_valid,
    output logic [EXP_W+MAN_W:0]   out_bf16,
    output logic                   out_ovf,
    output logic                   out_unf,
    output logic                   out_invalid,
    output acc_state_t             dbg_state
);

    localparam logic signed [9:0] EMAX = 10'(EXP_MAX);

    acc_state_t        state_q, state_d;
    logic [15:0]       op_q, op_d, acc_q, acc_d;
    logic              last_q, last_d;
    logic [2:0]        sticky_q, sticky_d;
    logic [SIG_W-1:0]  sig_big_q, sig_big_d, sig_small_q, sig_small_d;
    logic [7:0]        exp_big_q, exp_big_d;
    logic              sign_q, sign_d, sub_q, sub_d;
    logic              spec_q, spec_d, spec_inv_q, spec_inv_d;
    logic [15:0]       spec_val_q, spec_val_d;
    logic              out_valid_q, out_valid_d;
    logic [15:0]       out_bf16_q, out_bf16_d;
    logic [2:0]        out_flags_q, out_flags_d;

    // ALIGN datapath, a pure function of acc_q and op_q.
    logic              a_zero, b_zero, a_is_big, s_lost;
    logic [14:0]       a_mag, b_mag;
    logic [SIG_W-1:0]  a_sig, b_sig, s_big, s_small, s_shift;
    logic [7:0]        e_big, e_small, e_diff;
    logic              a_nan, b_nan, a_inf, b_inf;

    always_comb begin
        a_zero   = (acc_q[14:7] == 8'd0);
        b_zero   = (op_q[14:7] == 8'd0);
        a_mag    = a_zero ? 15'd0 : acc_q[14:0];
        b_mag    = b_zero ? 15'd0 : op_q[14:0];
        a_sig    = a_zero ? '0 : {1'b1, acc_q[6:0], 3'b000};
        b_sig    = b_zero ? '0 : {1'b1, op_q[6:0], 3'b000};
        a_is_big = (a_mag >= b_mag);
        e_big    = a_is_big ? a_mag[14:7] : b_mag[14:7];
        e_small  = a_is_big ? b_mag[14:7] : a_mag[14:7];
        s_big    = a_is_big ? a_sig : b_sig;
        s_small  = a_is_big ? b_sig : a_sig;
        e_diff   = e_big - e_small;
        s_lost   = 1'b0;
        if (e_diff >= 8'd11) begin
            s_shift = {{(SIG_W-1){1'b0}}, |s_small};
        end else begin
            s_lost  = |(s_small & ~({SIG_W{1'b1}} << e_diff[3:0]));
            s_shift = s_small >> e_diff[3:0];
            s_shift[0] = s_shift[0] | s_lost;
        end
        a_nan = bf16_is_nan(acc_q);
        b_nan = bf16_is_nan(op_q);
        a_inf = bf16_is_inf(acc_q);
        b_inf = bf16_is_inf(op_q);
    end

    // NORM datapath, operating on the registered aligned pair.
    logic [SUM_W-1:0]  sum, sum_sh;
    logic [3:0]        lz, lsh;
    logic [SIG_W-1:0]  mant;
    logic signed [9:0] e_n;
    logic              rnd;
    logic [8:0]        m_r;
    logic [15:0]       res;
    logic [2:0]        res_flags;

    lzc12 u_lzc (
        .vec (sum),
        .cnt (lz)
    );

    always_comb begin
        sum    = sub_q ? ({1'b0, sig_big_q} - {1'b0, sig_small_q})
                       : ({1'b0, sig_big_q} + {1'b0, sig_small_q});
        lsh    = lz - 4'd1;
        sum_sh = sum << lsh;
        if (sum[SUM_W-1]) begin
            mant = {sum[11:2], sum[1] | sum[0]};
            e_n  = $signed({2'b00, exp_big_q}) + 10'sd1;
        end else begin
            mant = sum_sh[SIG_W-1:0];
            e_n  = $signed({2'b00, exp_big_q}) - $signed({6'b000000, lsh});
        end
        rnd = mant[2] & (mant[3] | mant[1] | mant[0]);
        m_r = {1'b0, mant[10:3]} + {8'd0, rnd};
        if (m_r[8]) e_n = e_n + 10'sd1;
        res       = 16'h0000;
        res_flags = 3'b000;
        if (spec_q) begin
            res       = spec_val_q;
            res_flags = {2'b00, spec_inv_q};
        end else if (sum == '0) begin
            res = 16'h0000;
        end else if (e_n >= EMAX) begin
            res       = sign_q ? BF16_NINF : BF16_PINF;
            res_flags = 3'b100;
        end else if (e_n <= 10'sd0) begin
            res_flags = 3'b010;
        end else begin
            res = {sign_q, e_n[7:0], m_r[6:0]};
        end
    end

    assign in_ready = (state_q == IDLE) && !clr;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        last_d      = last_q;
        acc_d       = acc_q;
        sticky_d    = sticky_q;
        sig_big_d   = sig_big_q;
        sig_small_d = sig_small_q;
        exp_big_d   = exp_big_q;
        sign_d      = sign_q;
        sub_d       = sub_q;
        spec_d      = spec_q;
        spec_inv_d  = spec_inv_q;
        spec_val_d  = spec_val_q;
        out_valid_d = 1'b0;
        out_bf16_d  = out_bf16_q;
        out_flags_d = out_flags_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    op_d     = in_bf16;
                    last_d   = in_last;
                    sticky_d = sticky_q | {in_ovf, in_unf, in_invalid};
                    state_d  = ALIGN;
                end
            end
            ALIGN: begin
                sig_big_d   = s_big;
                sig_small_d = s_shift;
                exp_big_d   = e_big;
                sign_d      = a_is_big ? acc_q[15] : op_q[15];
                sub_d       = acc_q[15] ^ op_q[15];
                spec_d      = 1'b0;
                spec_inv_d  = 1'b0;
                spec_val_d  = 16'h0000;
                if (a_nan || b_nan || (a_inf && b_inf && (acc_q[15] != op_q[15]))) begin
                    spec_d     = 1'b1;
                    spec_inv_d = 1'b1;
                    spec_val_d = BF16_QNAN;
                end else if (a_inf) begin
                    spec_d     = 1'b1;
                    spec_val_d = acc_q;
                end else if (b_inf) begin
                    spec_d     = 1'b1;
                    spec_val_d = op_q;
                end
                state_d = NORM;
            end
            NORM: begin
                state_d = IDLE;
                if (last_q) begin
                    out_valid_d = 1'b1;
                    out_bf16_d  = res;
                    out_flags_d = sticky_q | res_flags;
                    acc_d       = 16'h0000;
                    sticky_d    = 3'b000;
                end else begin
                    acc_d    = res;
                    sticky_d = sticky_q | res_flags;
                end
            end
            default: state_d = IDLE;
        endcase
        // Abort wins over any accept, in-flight op or pending result pulse.
        if (clr) begin
            state_d     = IDLE;
            acc_d       = 16'h0000;
            sticky_d    = 3'b000;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            op_q        <= '0;
            last_q      <= 1'b0;
            acc_q       <= '0;
            sticky_q    <= '0;
            sig_big_q   <= '0;
            sig_small_q <= '0;
            exp_big_q   <= '0;
            sign_q      <= 1'b0;
            sub_q       <= 1'b0;
            spec_q      <= 1'b0;
            spec_inv_q  <= 1'b0;
            spec_val_q  <= '0;
            out_valid_q <= 1'b0;
            out_bf16_q  <= '0;
            out_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            last_q      <= last_d;
            acc_q       <= acc_d;
            sticky_q    <= sticky_d;
            sig_big_q   <= sig_big_d;
            sig_small_q <= sig_small_d;
            exp_big_q   <= exp_big_d;
            sign_q      <= sign_d;
            sub_q       <= sub_d;
            spec_q      <= spec_d;
            spec_inv_q  <= spec_inv_d;
            spec_val_q  <= spec_val_d;
            out_valid_q <= out_valid_d;
            out_bf16_q  <= out_bf16_d;
            out_flags_q <= out_flags_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_bf16    = out_bf16_q;
    assign out_ovf     = out_flags_q[2];
    assign out_unf     = out_flags_q[1];
    assign out_invalid = out_flags_q[0];
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_acc_bf16.sv
// Bench for acc_bf16: directed spec cases plus random runs scored against a real-arithmetic model.
module tb_acc_bf16;
    import bf16_pkg::*;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        nRST, clr, in_valid, in_last, in_ovf, in_unf, in_invalid;
    logic [15:0] in_bf16;
    logic        in_ready, out_valid, out_ovf, out_unf, out_invalid;
    logic [15:0] out_bf16;
    acc_state_t  dbg_state;

    always #5 clk = ~clk;

    acc_bf16 dut (
        .clk         (clk),
        .nRST        (nRST),
        .clr         (clr),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_bf16     (in_bf16),
        .in_last     (in_last),
        .in_ovf      (in_ovf),
        .in_unf      (in_unf),
        .in_invalid  (in_invalid),
        .out_valid   (out_valid),
        .out_bf16    (out_bf16),
        .out_ovf     (out_ovf),
        .out_unf     (out_unf),
        .out_invalid (out_invalid),
        .dbg_state   (dbg_state)
    );

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int pushed = 0;
    logic [18:0] exp_q[$];
    logic [15:0] m_acc = 16'h0000;
    logic [2:0]  m_sticky = 3'b000;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, expv);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic real bf_to_real(input logic [15:0] v);
        real r;
        int  e;
        if (v[14:7] == 8'd0) return 0.0;
        r = 128.0 + v[6:0];
        e = int'(v[14:7]) - 134;
        while (e > 0) begin r = r * 2.0; e--; end
        while (e < 0) begin r = r / 2.0; e++; end
        return v[15] ? -r : r;
    endfunction

    function automatic logic [18:0] real_to_bf(input real r);
        real  x, frac, rem;
        int   e, t, be;
        logic s;
        if (r == 0.0) return 19'd0;
        s = (r < 0.0);
        x = s ? -r : r;
        e = 0;
        while (x >= 2.0) begin x = x / 2.0; e++; end
        while (x < 1.0) begin x = x * 2.0; e--; end
        frac = x * 128.0;
        t    = $rtoi(frac);
        rem  = frac - t;
        if (rem > 0.5 || (rem == 0.5 && (t % 2) == 1)) t++;
        if (t == 256) begin t = 128; e++; end
        be = e + 127;
        if (be >= 255) return {3'b100, s ? BF16_NINF : BF16_PINF};
        if (be <= 0) return {3'b010, 16'h0000};
        return {3'b000, s, 8'(be), 7'(t - 128)};
    endfunction

    function automatic logic [18:0] ref_add(input logic [15:0] a, input logic [15:0] b);
        logic a_nan, b_nan, a_inf, b_inf;
        a_nan = (a[14:7] == 8'hFF) && (a[6:0] != 7'd0);
        b_nan = (b[14:7] == 8'hFF) && (b[6:0] != 7'd0);
        a_inf = (a[14:7] == 8'hFF) && (a[6:0] == 7'd0);
        b_inf = (b[14:7] == 8'hFF) && (b[6:0] == 7'd0);
        if (a_nan || b_nan) return {3'b001, BF16_QNAN};
        if (a_inf && b_inf) return (a[15] != b[15]) ? {3'b001, BF16_QNAN} : {3'b000, a};
        if (a_inf) return {3'b000, a};
        if (b_inf) return {3'b000, b};
        return real_to_bf(bf_to_real(a) + bf_to_real(b));
    endfunction

    task automatic model_feed(input logic [15:0] v, input logic last, input logic [2:0] f);
        logic [18:0] r;
        r = ref_add(m_acc, v);
        m_sticky = m_sticky | f | r[18:16];
        if (last) begin
            exp_q.push_back({m_sticky, r[15:0]});
            pushed++;
            m_acc = 16'h0000;
            m_sticky = 3'b000;
        end else begin
            m_acc = r[15:0];
        end
    endtask

    function automatic logic [15:0] rand_bf16();
        int sel;
        logic s;
        s = 1'($urandom_range(0, 1));
        sel = $urandom_range(0, 39);
        if (sel == 0) return {s, 8'h00, 7'($urandom_range(0, 127))};
        if (sel == 1) return {s, 8'hFF, 7'h00};
        if (sel == 2) return {s, 8'hFF, 7'($urandom_range(1, 127))};
        if (sel < 6)  return {s, 8'($urandom_range(1, 254)), 7'($urandom_range(0, 127))};
        if (sel < 8)  return {s, ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 3)) : 8'($urandom_range(252, 254)),
                              7'($urandom_range(0, 127))};
        return {s, 8'($urandom_range(122, 132)), 7'($urandom_range(0, 127))};
    endfunction

    // ---------------- scoreboard monitor ----------------
    logic        prev_ov = 1'b0;
    logic [18:0] exp_e;
    always @(negedge clk) begin
        if (!nRST) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid) begin
                pulses++;
                check_val("out_valid_one_cycle", {31'd0, prev_ov}, 32'd0);
                if (exp_q.size() == 0) begin
                    check_val("stray_out_valid", {31'd0, out_valid}, 32'd0);
                end else begin
                    exp_e = exp_q.pop_front();
                    check_val("result", {13'd0, out_ovf, out_unf, out_invalid, out_bf16}, {13'd0, exp_e});
                end
            end
            prev_ov = out_valid;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic accept_op(input logic [15:0] v, input logic last, input logic [2:0] f);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_bf16  = v;
        in_last  = last;
        {in_ovf, in_unf, in_invalid} = f;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_val("accept_timeout", {31'd0, n < 50}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        {in_ovf, in_unf, in_invalid} = 3'b000;
        in_bf16  = 16'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_val("drain_timeout", exp_q.size(), 32'd0);
    endtask

    task automatic directed(input logic [15:0] a, input logic [15:0] b, input logic [18:0] expv);
        accept_op(a, 1'b0, 3'b000);
        accept_op(b, 1'b1, 3'b000);
        exp_q.push_back(expv);
        pushed++;
        drain();
    endtask

    task automatic single(input logic [15:0] a, input logic [18:0] expv);
        accept_op(a, 1'b1, 3'b000);
        exp_q.push_back(expv);
        pushed++;
        drain();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [15:0] v;
        logic [2:0]  f;
        int          len;
        nRST = 1'b1; clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_ovf = 1'b0; in_unf = 1'b0; in_invalid = 1'b0; in_bf16 = 16'h0000;
        #1 nRST = 1'b0;
        #20;
        check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_out", {13'd0, out_ovf, out_unf, out_invalid, out_bf16}, 32'd0);
        check_val("rst_state", {30'd0, dbg_state}, {30'd0, IDLE});
        @(negedge clk);
        nRST = 1'b1;

        // 1.0 + 2.0 with exact pulse timing.
        accept_op(16'h3F80, 1'b0, 3'b000);
        accept_op(16'h4000, 1'b1, 3'b000);
        exp_q.push_back({3'b000, 16'h4040});
        pushed++;
        @(negedge clk); check_val("lat_edge0", {31'd0, out_valid}, 32'd0);
        @(negedge clk); check_val("lat_edge1", {31'd0, out_valid}, 32'd0);
        @(negedge clk); check_val("lat_edge2", {31'd0, out_valid}, 32'd1);
        @(negedge clk); check_val("lat_edge3", {31'd0, out_valid}, 32'd0);
        drain();

        directed(16'h3F80, 16'hBF80, {3'b000, 16'h0000});
        single(16'h4000, {3'b000, 16'h4000});
        directed(16'h3F80, 16'h3B80, {3'b000, 16'h3F80});
        directed(16'h3F81, 16'h3B80, {3'b000, 16'h3F82});
        directed(16'h3F80, 16'h3B81, {3'b000, 16'h3F81});
        directed(16'h7F7F, 16'h7F7F, {3'b100, 16'h7F80});
        directed(16'h7F80, 16'hFF80, {3'b001, 16'h7FC0});
        directed(16'h0080, 16'h8000, {3'b000, 16'h0080});

        // clr during ALIGN of a last op: nothing emitted.
        accept_op(16'h3F80, 1'b1, 3'b000);
        clr = 1'b1;
        #1 check_val("clr_ready_low", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1 clr = 1'b0;
        check_val("clr_state_idle", {30'd0, dbg_state}, {30'd0, IDLE});
        repeat (5) @(negedge clk);

        // clr during NORM of a last op, and clr coinciding with in_valid.
        accept_op(16'h4000, 1'b1, 3'b000);
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        @(negedge clk);
        clr = 1'b1; in_valid = 1'b1; in_bf16 = 16'h4000; in_last = 1'b1;
        @(posedge clk); #1;
        check_val("clr_blocks_accept", {30'd0, dbg_state}, {30'd0, IDLE});
        clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        repeat (5) @(negedge clk);

        // clr must wipe a partial accumulation and its sticky flags.
        accept_op(16'h4000, 1'b0, 3'b100);
        repeat (4) @(negedge clk);
        clr = 1'b1;
        @(negedge clk) clr = 1'b0;
        single(16'h3F80, {3'b000, 16'h3F80});

        // nRST during NORM.
        accept_op(16'h4000, 1'b1, 3'b011);
        @(posedge clk); #2 nRST = 1'b0;
        #1;
        check_val("nrst_in_ready", {31'd0, in_ready}, 32'd1);
        check_val("nrst_out", {12'd0, out_valid, out_ovf, out_unf, out_invalid, out_bf16}, 32'd0);
        @(negedge clk) nRST = 1'b1;
        repeat (4) @(negedge clk);
        single(16'h3F80, {3'b000, 16'h3F80});

        // in_valid held high with a fresh value every cycle.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            v = {1'($urandom_range(0, 1)), 8'($urandom_range(124, 130)), 7'($urandom_range(0, 127))};
            in_valid = 1'b1;
            in_bf16  = v;
            in_last  = (i == 6);
            check_val("ready_pattern", {31'd0, in_ready}, {31'd0, (i % 3) == 0});
            if (in_ready) model_feed(v, i == 6, 3'b000);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        drain();

        // Random runs against the model.
        for (int r = 0; r < 40; r++) begin
            len = $urandom_range(1, 4);
            for (int k = 0; k < len; k++) begin
                v = rand_bf16();
                f = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
                accept_op(v, k == len - 1, f);
                model_feed(v, k == len - 1, f);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        drain();
        repeat (4) @(negedge clk);
        check_val("pulse_count", pulses, pushed);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/acc_bf16.md
# acc_bf16

Sequential BF16 accumulator that consumes the product stream from the systolic-array PE multiplier and produces one dot-product result per `in_last`-terminated run. It sits directly downstream of the BF16 multiplier in each processing element. It performs a two-stage pipelined add (align, then add/normalize/round, RNE) into an internal accumulator register. Input is accepted through a valid/ready handshake, and the result is emitted as a one-cycle `out_valid` pulse together with sticky exception flags.

## Interface
- `EXP_W`, 8: exponent width (BF16; fixed, exposed for package consistency)
- `MAN_W`, 7: stored mantissa width
- `clk`  in  1  clock
- `nRST`  in  1  reset, asynchronous, active-low
- `clr`  in  1  synchronous abort: acc := +0, flags cleared, FSM to IDLE
- `in_valid`  in  1  product available
- `in_ready`  out  1  block can accept (high only in IDLE and `clr`=0)
- `in_bf16`  in  16  product operand {sign, exp[7:0], man[6:0]}
- `in_last`  in  1  operand is final term of current dot product
- `in_ovf`, `in_unf`, `in_invalid`  in  1 each  multiplier flags, OR-ed into sticky flags on accept
- `out_valid`  out  1  one-cycle result pulse
- `out_bf16`  out  16  accumulated result, held until next result
- `out_ovf`, `out_unf`, `out_invalid`  out  1 each  sticky flags for the emitted result

## Operation
- FSM states: IDLE, ALIGN, NORM.
  - IDLE: on accept (`in_valid & in_ready`), latch operand, `last`, and flags; go to ALIGN.
  - ALIGN: go to NORM unconditionally.
  - NORM: go to IDLE unconditionally.
- ALIGN stage:
  - Compare acc and operand exponents.
  - Form 11-bit significands {hidden, man[6:0], G, R, S}.
  - Right-shift the smaller significand by the exponent difference, OR-ing shifted-out bits into S.
  - Difference ≥ 11: smaller significand becomes 0, with S = OR of all its bits.
  - Register the aligned pair, larger exponent, signs, and effective operation.
- NORM stage:
  - Same signs: add. Different signs: larger-magnitude minus smaller; result sign = sign of larger.
  - 12-bit sum. Carry out: shift right 1, exponent +1, S absorbs the dropped bit.
  - Otherwise left-normalize by leading-zero count.
  - Round to nearest, ties to even, on G/R/S.
  - Rounding carry renormalizes and increments the exponent.
- Zero and subnormal: exponent 0 is treated as ±0 (flush-to-zero) on inputs. A result exponent ≤ 0 gives +0 and sets `unf`.
- Exact cancellation gives +0.
- Overflow: result exponent ≥ 255 gives ±inf (0x7F80/0xFF80) and sets `ovf`.
- Special cases:
  - Any NaN operand gives canonical 0x7FC0 and sets `invalid`.
  - +inf + −inf gives 0x7FC0 and sets `invalid`.
  - inf + finite gives that inf, with no flag.
  - Once acc is NaN it stays NaN until emitted or cleared.
- On leaving NORM with `last` set:
  - `out_bf16` := result; `out_valid` pulses; out flags := sticky flags.
  - acc := +0 and sticky flags clear in the same edge.
- On leaving NORM with `last` clear: acc := result.

## Timing
- Reset values:
  - `in_ready`=1, `out_valid`=0, `out_bf16`=16'h0000, all out flags 0.
  - acc=+0, FSM=IDLE, sticky flags 0.
- Latency and throughput:
  - Accept at edge E0 → ALIGN; E1 → NORM; E2 writes acc.
  - For `last`, `out_valid`=1 during the cycle after E2, i.e. 2 edges after accept.
  - Throughput is one operand per 3 cycles; `in_ready` is combinational from state and `clr`.
- `clr` has priority over everything:
  - A same-cycle `clr` and `in_valid` accepts nothing.
  - An in-flight op is discarded with no `out_valid`.
  - `clr` in the NORM cycle of a `last` op suppresses that op's pulse.
- `nRST` mid-operation aborts immediately; no output pulse follows.
- `in_bf16` may change while `in_ready`=0; only the accepted value is used.

## Structure
- Package `bf16_pkg`:
  - Field widths and `BIAS`=127.
  - `BF16_QNAN`=16'h7FC0, `BF16_PINF`=16'h7F80, `BF16_NINF`=16'hFF80.
  - Significand width 11, state enum `acc_state_t`.
  - Shared with the multiplier.
- One sub-module: `lzc12`, a combinational 12-bit leading-zero counter returning a 4-bit count, used by NORM.

## Test plan
- Sum: 0x3F80, then 0x4000 with `in_last`. Required: `out_bf16`=0x4040, `out_valid` exactly one cycle, 2 edges after the second accept, flags 0.
- Cancellation and follow-on run: 0x3F80, then 0xBF80(last) → 0x0000. A following run 0x4000(last) → 0x4000, confirming acc was reset.
- Rounding, ties-to-even:
  - 0x3F80 + 0x3B80(last) → 0x3F80.
  - 0x3F81 + 0x3B80(last) → 0x3F82.
  - 0x3F80 + 0x3B81(last) → 0x3F81 (sticky rounds up).
- Exceptions:
  - 0x7F7F + 0x7F7F(last) → 0x7F80 with `out_ovf`=1.
  - 0x7F80 + 0xFF80(last) → 0x7FC0 with `out_invalid`=1.
  - 0x0080 + 0x8000(last) → 0x0080.
- Abort:
  - `clr` asserted during ALIGN of a `last` op: no `out_valid`.
  - `nRST` pulse during NORM: all outputs return to reset values.
  - Subsequent 0x3F80(last) → 0x3F80.
- Handshake: `in_valid` held high with a new value every cycle. Only every third value is accepted, `in_ready` follows the 1,0,0 pattern, and the sum matches the accepted subset.
